// File: rtl/frame_update_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_update_arbiter
//  Description : Grants frame-buffer update access to one of N_REQ requesters
//                during vertical blanking. Each frame's grants go out in
//                round-robin order, and a requester gets at most one grant per
//                frame. A grant ends when its requester pulses done or when the
//                timeout expires.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    pclk        in   1      pixel clock, rising edge
//    rst         in   1      synchronous active-high reset
//    vblnk       in   1      vertical blanking flag (pclk domain)
//    req         in   N_REQ  per-requester update request (level)
//    done        in   N_REQ  per-requester completion pulse
//    gnt         out  N_REQ  registered one-hot grant, or zero
//    busy        out  1      high while a grant is active
//    frame_start out  1      one-cycle pulse at start of vertical blank
//    timeout     out  1      one-cycle pulse when a grant is revoked by timeout
//    overrun     out  1      sticky: blanking ended while a grant was active
//    frame_cnt   out  16     number of frame_start pulses (wraps)
// ============================================================================
module frame_update_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vblnk,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             busy,
  output logic             frame_start,
  output logic             timeout,
  output logic             overrun,
  output logic [15:0]      frame_cnt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0]    LAST_RST = IW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t           state;
  logic             vblnk_d;
  logic [N_REQ-1:0] served;
  logic [IW-1:0]    last_granted;
  logic [CW-1:0]    grant_cnt;

  logic             rise;
  logic             fall;
  logic [N_REQ-1:0] pending;
  logic             done_hit;
  logic             expire;
  logic             grant_end;
  logic [IW-1:0]    sel;
  logic             sel_valid;

  assign rise      = vblnk & ~vblnk_d;
  assign fall      = ~vblnk & vblnk_d;
  assign pending   = req & ~served;
  assign done_hit  = |(done & gnt);
  assign expire    = (grant_cnt == CNT_LAST);
  assign grant_end = (state == GRANT) && (done_hit || expire);
  assign busy      = (state == GRANT);

  // Round-robin pick: scan offsets from the farthest to the nearest so the
  // last hit is the first pending index after last_granted.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      logic [IW-1:0] idx;
      idx = IW'((int'(last_granted) + i) % N_REQ);
      if (pending[idx]) begin
        sel       = idx;
        sel_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      frame_start  <= 1'b0;
      timeout      <= 1'b0;
      overrun      <= 1'b0;
      frame_cnt    <= '0;
      served       <= '0;
      vblnk_d      <= 1'b0;
      last_granted <= LAST_RST;
      grant_cnt    <= '0;
    end else begin
      vblnk_d     <= vblnk;
      // frame_start, the frame_cnt increment and the IDLE->SCAN move all
      // take effect on the same edge, so SCAN already sees a cleared mask.
      frame_start <= rise;
      timeout     <= 1'b0;

      if (rise) begin
        frame_cnt <= frame_cnt + 16'd1;
      end

      // A new frame clears the mask; otherwise a finishing grant marks its
      // requester as served.
      if (rise) begin
        served <= '0;
      end else if (grant_end) begin
        served <= served | gnt;
      end

      if (fall && (state == GRANT)) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (rise) begin
            state <= SCAN;
          end
        end

        SCAN: begin
          if (vblnk && sel_valid) begin
            gnt          <= ONE_HOT0 << sel;
            last_granted <= sel;
            grant_cnt    <= '0;
            state        <= GRANT;
          end else begin
            // Stay in SCAN if a new blanking period starts right now, so
            // that frame is not missed.
            state <= rise ? SCAN : IDLE;
          end
        end

        GRANT: begin
          if (done_hit) begin
            gnt   <= '0;
            state <= SCAN;
          end else if (expire) begin
            gnt     <= '0;
            timeout <= 1'b1;
            state   <= SCAN;
          end else begin
            grant_cnt <= grant_cnt + 1'b1;
          end
        end

        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
